pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_edge_sync.sv | 32 +++
 rtl/pwm_capture.sv | 108 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and sizing helpers for the PWM duty-cycle decoder.
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_RES = 12;

  // Nominal PWM period in clk cycles for a given resolution.
  function automatic int unsigned nominal_period(input int unsigned res);
    return 32'd1 << res;
  endfunction

  // Cycles without a rising edge before the input is treated as constant.
  function automatic int unsigned timeout_count(input int unsigned res);
    return 32'd1 << (res + 1);
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM input and flags its rising edges.
module pwm_edge_sync
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  // NOTE: sequential state uses non-blocking assignments with an async
  // active-low reset so every flop updates together on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_capture.sv
// Recovers the duty value of a PWM waveform by counting high cycles per period,
// with period checking and a timeout that reports constant-level inputs.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int nBitRes     = DEFAULT_RES,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwm_in,
  output logic [nBitRes-1:0] ubit_voltage,
  output logic               valid,
  output logic               period_err,
  output logic               locked
);

  localparam int PW = nBitRes + 2;
  localparam int HW = nBitRes + 1;
  localparam logic [PW-1:0] NOM_PERIOD = PW'(nominal_period(nBitRes));
  localparam logic [PW-1:0] TIMEOUT    = PW'(timeout_count(nBitRes));
  localparam logic [HW-1:0] DUTY_MAX   = HW'((1 << nBitRes) - 1);

  logic s;
  logic rise;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .s     (s),
    .rise  (rise)
  );

  state_t              state, state_nxt;
  logic [PW-1:0]       per_cnt, per_nxt, per_inc;
  logic [HW-1:0]       hi_cnt, hi_nxt, hi_inc;
  logic [nBitRes-1:0]  ubit_nxt;
  logic                valid_nxt;
  logic                perr_nxt;
  logic                locked_nxt;
  logic                timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      ubit_voltage <= '0;
      valid        <= 1'b0;
      period_err   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nxt;
      per_cnt      <= per_nxt;
      hi_cnt       <= hi_nxt;
      ubit_voltage <= ubit_nxt;
      valid        <= valid_nxt;
      period_err   <= perr_nxt;
      locked       <= locked_nxt;
    end
  end

  // Saturating increments: counters hold at all-ones instead of wrapping.
  assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + PW'(1);
  assign hi_inc  = (hi_cnt == '1) ? hi_cnt : hi_cnt + HW'(1);
  assign timeout = (per_cnt == TIMEOUT);

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    ubit_nxt   = ubit_voltage;
    valid_nxt  = 1'b0;
    perr_nxt   = period_err;
    locked_nxt = locked;

    if (rise) begin
      // A rise always wins over a coincident timeout.
      per_nxt   = PW'(1);
      hi_nxt    = HW'(1);
      state_nxt = MEASURE;
      if (state == MEASURE) begin
        ubit_nxt   = (hi_cnt > DUTY_MAX) ? '1 : hi_cnt[nBitRes-1:0];
        perr_nxt   = (per_cnt != NOM_PERIOD);
        locked_nxt = (per_cnt == NOM_PERIOD);
        valid_nxt  = 1'b1;
      end
    end else if (timeout) begin
      ubit_nxt   = s ? '1 : '0;
      valid_nxt  = 1'b1;
      perr_nxt   = 1'b0;
      locked_nxt = 1'b0;
      per_nxt    = PW'(1);
      state_nxt  = IDLE;
    end else begin
      per_nxt = per_inc;
      if (state == MEASURE && s) begin
        hi_nxt = hi_inc;
      end
    end
  end

endmodule
